if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
Instruction-fetch controller between the PC register and the IF/ID pipeline register. It takes the current PC and chip-enable, issues single-outstanding read requests to instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a small FIFO. It presents buffered instructions to the IF/ID stage over a valid/ready handshake and pulses an advance strobe so the PC stage steps only when a fetch is actually launched. A flush, used for branch redirects, discards buffered and in-flight fetches.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
BUF_DEPTH, 2, output FIFO entries; legal values are 2 and 4

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
pc_i  in  ADDR_W  PC to fetch from
ce_i  in  1  fetch enable from PC stage; 1 = enabled
pc_adv_o  out  1  one-cycle pulse: pc_i consumed, PC stage may advance
flush_i  in  1  discard all buffered and in-flight fetches
imem_req_o  out  1  memory read request
imem_addr_o  out  ADDR_W  memory read address
imem_ack_i  in  1  memory response valid, one cycle per request
imem_rdata_i  in  DATA_W  memory read data, valid with ack
inst_valid_o  out  1  FIFO head valid
inst_o  out  DATA_W  FIFO head instruction
inst_pc_o  out  ADDR_W  FIFO head PC
inst_misalign_o  out  1  FIFO head fetched from a misaligned PC
id_ready_i  in  1  IF/ID accepts head this cycle

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock.
  - State goes to IDLE and FIFO count to 0.
  - imem_req_o=0, imem_addr_o=0, pc_adv_o=0, inst_valid_o=0.
  - inst_o=0, inst_pc_o=0, inst_misalign_o=0.
  - Reset mid-request drops the request immediately. The memory side must tolerate this.
- FSM states: IDLE, REQ, DROP.
- IDLE → launch when ce_i=1, flush_i=0 and a slot is free. "Free" means count < BUF_DEPTH after any pop this cycle is counted.
  - Aligned launch (pc_i[1:0]=0): register imem_addr_o=pc_i, set imem_req_o=1 next cycle, pulse pc_adv_o, go to REQ.
  - Misaligned launch (pc_i[1:0]≠0): no memory access. Push {inst=0, pc=pc_i, misalign=1}, pulse pc_adv_o, stay in IDLE.
- REQ: hold imem_req_o and imem_addr_o stable until imem_ack_i.
  - On ack: push {imem_rdata_i, imem_addr_o, 0}, deassert req, go to IDLE.
  - Minimum issue interval is 2 cycles per aligned fetch.
- flush_i in IDLE: empty the FIFO; no launch that cycle.
- flush_i in REQ:
  - Without ack: empty the FIFO and go to DROP. Req stays asserted until ack; the protocol forbids withdrawing an unacked request.
  - With ack in the same cycle: discard the response, go to IDLE.
- DROP: on ack, discard data, deassert req, go to IDLE. flush_i in DROP only empties the FIFO.
- FIFO:
  - inst_valid_o = (count≠0); the head drives inst_o, inst_pc_o and inst_misalign_o.
  - Pop when inst_valid_o & id_ready_i & ~flush_i.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo BUF_DEPTH.
  - Head outputs are 0 when the FIFO is empty.
- Flush has priority over push, pop and launch in every state.
- pc_adv_o is never asserted while ce_i=0, while flush_i=1, or when no launch occurs.
- Address is used unmodified; no PC arithmetic in this block.

Test Plan:
1. Reset then ce_i=1, pc_i=0x0, memory acks 1 cycle after req with 0x3C010001 → pc_adv_o pulse, imem_addr_o=0x0, next cycle inst_valid_o=1, inst_o=0x3C010001, inst_pc_o=0x0.
2. id_ready_i=0, fetch PCs 0x0, 0x4, 0x8 → two entries buffered, third not launched, no pc_adv_o for 0x8 until a pop; head stays 0x0 until ready.
3. Request to 0x10 outstanding with ack delayed 3 cycles, flush_i pulsed at cycle 1 → req held until ack, response discarded, inst_valid_o=0, then fetch from new pc_i=0x100 proceeds.
4. flush_i coincident with imem_ack_i → response dropped, FIFO empty, IDLE next cycle; buffered entries also cleared.
5. pc_i=0x6 → no imem_req_o, pc_adv_o pulse, head inst_o=0, inst_pc_o=0x6, inst_misalign_o=1.
6. rst asserted while in REQ with two entries buffered → all outputs 0 next cycle, count 0, state IDLE.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: issues single-outstanding imem reads and buffers
// fetched words with their PCs in a small FIFO toward the IF/ID register.
module if_fetch_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              ce_i,
    output logic              pc_adv_o,
    input  logic              flush_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [DATA_W-1:0] imem_rdata_i,
    output logic              inst_valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_misalign_o,
    input  logic              id_ready_i
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]  count_reg, count_next;

    logic [DATA_W-1:0] inst_mem [BUF_DEPTH];
    logic [ADDR_W-1:0] pc_mem   [BUF_DEPTH];
    logic              mis_mem  [BUF_DEPTH];

    logic              push, pop, slot_free;
    logic [DATA_W-1:0] push_inst;
    logic [ADDR_W-1:0] push_pc;
    logic              push_mis;

    assign inst_valid_o    = (count_reg != '0);
    assign pop             = inst_valid_o & id_ready_i & ~flush_i;
    // A slot freed by this cycle's pop may be reused by this cycle's launch.
    assign slot_free       = (count_reg - CNT_W'(pop)) < CNT_W'(BUF_DEPTH);

    assign imem_req_o      = (state_reg != IDLE);
    assign imem_addr_o     = addr_reg;
    assign inst_o          = inst_valid_o ? inst_mem[rd_ptr_reg] : '0;
    assign inst_pc_o       = inst_valid_o ? pc_mem[rd_ptr_reg]   : '0;
    assign inst_misalign_o = inst_valid_o ? mis_mem[rd_ptr_reg]  : 1'b0;

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        push       = 1'b0;
        push_inst  = '0;
        push_pc    = '0;
        push_mis   = 1'b0;
        pc_adv_o   = 1'b0;
        if (!rst) begin
            case (state_reg)
                IDLE: begin
                    if (ce_i && !flush_i && slot_free) begin
                        pc_adv_o = 1'b1;
                        if (pc_i[1:0] == 2'b00) begin
                            addr_next  = pc_i;
                            state_next = REQ;
                        end else begin
                            // Misaligned PCs never reach memory; tag them for ID.
                            push     = 1'b1;
                            push_pc  = pc_i;
                            push_mis = 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (imem_ack_i) begin
                        state_next = IDLE;
                        if (!flush_i) begin
                            push      = 1'b1;
                            push_inst = imem_rdata_i;
                            push_pc   = addr_reg;
                        end
                    end else if (flush_i) begin
                        state_next = DROP;
                    end
                end
                DROP: begin
                    if (imem_ack_i) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (flush_i) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            wr_ptr_next = wr_ptr_reg + PTR_W'(push);
            rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
            count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr_reg] <= push_inst;
            pc_mem[wr_ptr_reg]   <= push_pc;
            mis_mem[wr_ptr_reg]  <= push_mis;
        end
    end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios plus a random phase, all checked
// against a transaction-level model (queue of fetched entries + outstanding fetch).
module tb_if_fetch_ctrl;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pc_i = '0;
    logic          ce_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          imem_ack_i = 1'b0;
    logic [DW-1:0] imem_rdata_i = '0;
    logic          id_ready_i = 1'b0;
    logic          pc_adv_o, imem_req_o, inst_valid_o, inst_misalign_o;
    logic [AW-1:0] imem_addr_o, inst_pc_o;
    logic [DW-1:0] inst_o;

    if_fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .pc_adv_o(pc_adv_o),
        .flush_i(flush_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .inst_misalign_o(inst_misalign_o), .id_ready_i(id_ready_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] inst;
        logic [AW-1:0] pc;
        logic          mis;
    } ent_t;

    ent_t          q[$];
    bit            busy = 1'b0;
    bit            dead = 1'b0;
    logic [AW-1:0] m_addr = '0;
    int            n_cmp = 0;
    int            n_mis = 0;
    int            mem_lat = 0;
    int            wait_cnt = 0;
    logic [DW-1:0] mem_data = '0;
    logic          seen_adv = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs mid-cycle against the model, advance the
    // model, clock the DUT, then let the memory responder react.
    task automatic run(input bit do_chk = 1'b1);
        ent_t h;
        bit   pop, launch;
        int   sz;
        #4;
        sz = q.size();
        h = '{default: '0};
        if (sz != 0) h = q[0];
        pop    = (sz != 0) && id_ready_i && !flush_i;
        launch = !rst && !busy && ce_i && !flush_i && ((sz - int'(pop)) < DEPTH);
        seen_adv = pc_adv_o;
        if (do_chk) begin
            chk("inst_valid", inst_valid_o, sz != 0);
            chk("inst", inst_o, h.inst);
            chk("inst_pc", inst_pc_o, h.pc);
            chk("inst_mis", inst_misalign_o, h.mis);
            chk("imem_req", imem_req_o, busy);
            if (busy) chk("imem_addr", imem_addr_o, m_addr);
            chk("pc_adv", pc_adv_o, launch);
        end
        if (rst) begin
            q.delete();
            busy = 1'b0; dead = 1'b0; m_addr = '0;
        end else begin
            if (flush_i) q.delete();
            else if (pop) void'(q.pop_front());
            if (busy && imem_ack_i) begin
                if (!dead && !flush_i) q.push_back(ent_t'{imem_rdata_i, m_addr, 1'b0});
                busy = 1'b0; dead = 1'b0;
            end else if (busy && flush_i) begin
                dead = 1'b1;
            end
            if (launch) begin
                if (pc_i[1:0] == 2'b00) begin busy = 1'b1; m_addr = pc_i; end
                else q.push_back(ent_t'{'0, pc_i, 1'b1});
            end
        end
        @(posedge clk);
        #1;
        if (imem_ack_i) begin
            imem_ack_i = 1'b0; wait_cnt = 0;
        end else if (imem_req_o === 1'b1) begin
            if (wait_cnt >= mem_lat) begin imem_ack_i = 1'b1; imem_rdata_i = mem_data; end
            else wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic do_flush();
        flush_i = 1'b1; run(); flush_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (3) run(1'b0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_pc", inst_pc_o, 0);
        chk("rst_mis", inst_misalign_o, 0);
        chk("rst_req", imem_req_o, 0);
        chk("rst_addr", imem_addr_o, 0);
        chk("rst_adv", pc_adv_o, 0);
        rst = 1'b0;

        // 1: basic aligned fetch with one-cycle memory latency
        ce_i = 1'b1; pc_i = 32'h0; id_ready_i = 1'b1; mem_lat = 1; mem_data = 32'h3C010001;
        run();
        chk("t1_adv", seen_adv, 1);
        chk("t1_req", imem_req_o, 1);
        chk("t1_addr", imem_addr_o, 32'h0);
        ce_i = 1'b0;
        for (int i = 0; i < 10 && !inst_valid_o; i++) run();
        chk("t1_valid", inst_valid_o, 1);
        chk("t1_inst", inst_o, 32'h3C010001);
        chk("t1_inst_pc", inst_pc_o, 32'h0);
        do_flush();

        // 2: back-pressure fills the buffer, third fetch held until a pop
        id_ready_i = 1'b0; ce_i = 1'b1; pc_i = 32'h0; mem_lat = 0;
        for (int i = 0; i < 10; i++) begin
            mem_data = $urandom;
            run();
            if (seen_adv) pc_i = pc_i + 4;
        end
        chk("t2_pc_held", pc_i, 32'h8);
        chk("t2_valid", inst_valid_o, 1);
        chk("t2_head_pc", inst_pc_o, 32'h0);
        chk("t2_no_req", imem_req_o, 0);
        id_ready_i = 1'b1;
        run();
        chk("t2_adv_on_pop", seen_adv, 1);
        chk("t2_head_after_pop", inst_pc_o, 32'h4);
        chk("t2_req_8", imem_addr_o, 32'h8);
        id_ready_i = 1'b0; ce_i = 1'b0;
        run();
        do_flush();

        // 3: flush while a slow request is outstanding
        ce_i = 1'b1; pc_i = 32'h10; mem_lat = 3; mem_data = 32'hDEADBEEF;
        run();
        chk("t3_adv", seen_adv, 1);
        ce_i = 1'b0;
        do_flush();
        chk("t3_req_held", imem_req_o, 1);
        chk("t3_addr_held", imem_addr_o, 32'h10);
        for (int i = 0; i < 8 && imem_req_o; i++) run();
        chk("t3_req_done", imem_req_o, 0);
        chk("t3_discarded", inst_valid_o, 0);
        pc_i = 32'h100; ce_i = 1'b1; mem_lat = 0; mem_data = 32'h12345678;
        run();
        chk("t3_adv_new", seen_adv, 1);
        ce_i = 1'b0;
        for (int i = 0; i < 10 && !inst_valid_o; i++) run();
        chk("t3_new_pc", inst_pc_o, 32'h100);
        chk("t3_new_inst", inst_o, 32'h12345678);
        do_flush();

        // 4: flush coincident with ack, with an entry already buffered
        ce_i = 1'b1; pc_i = 32'h20; mem_lat = 0; mem_data = 32'hA5A5A5A5;
        run();
        ce_i = 1'b0;
        run();
        chk("t4_buffered", inst_valid_o, 1);
        ce_i = 1'b1; pc_i = 32'h24; mem_lat = 2; mem_data = 32'h5A5A5A5A;
        run();
        ce_i = 1'b0;
        for (int i = 0; i < 8 && !imem_ack_i; i++) run();
        chk("t4_ack_seen", imem_ack_i, 1);
        do_flush();
        chk("t4_empty", inst_valid_o, 0);
        chk("t4_req_off", imem_req_o, 0);
        ce_i = 1'b1; pc_i = 32'h30; mem_lat = 0;
        run();
        chk("t4_idle_launch", seen_adv, 1);
        ce_i = 1'b0;
        run();
        do_flush();

        // 5: misaligned PC bypasses memory
        ce_i = 1'b1; pc_i = 32'h6;
        run();
        chk("t5_adv", seen_adv, 1);
        ce_i = 1'b0;
        chk("t5_no_req", imem_req_o, 0);
        chk("t5_valid", inst_valid_o, 1);
        chk("t5_inst", inst_o, 0);
        chk("t5_pc", inst_pc_o, 32'h6);
        chk("t5_mis", inst_misalign_o, 1);
        do_flush();

        // 6: reset while a request is outstanding and the buffer holds data
        ce_i = 1'b1; pc_i = 32'h40; mem_lat = 0; mem_data = 32'h11112222;
        run();
        ce_i = 1'b0;
        run();
        ce_i = 1'b1; pc_i = 32'h44; mem_lat = 5;
        run();
        ce_i = 1'b0;
        run();
        chk("t6_pre_req", imem_req_o, 1);
        chk("t6_pre_valid", inst_valid_o, 1);
        rst = 1'b1;
        run();
        chk("t6_valid", inst_valid_o, 0);
        chk("t6_inst", inst_o, 0);
        chk("t6_pc", inst_pc_o, 0);
        chk("t6_mis", inst_misalign_o, 0);
        chk("t6_req", imem_req_o, 0);
        chk("t6_addr", imem_addr_o, 0);
        chk("t6_adv", pc_adv_o, 0);
        rst = 1'b0;
        run();

        // Random phase
        for (int i = 0; i < 400; i++) begin
            ce_i       = ($urandom_range(0, 9) < 7);
            id_ready_i = $urandom_range(0, 1);
            flush_i    = ($urandom_range(0, 19) == 0);
            rst        = ($urandom_range(0, 99) == 0);
            mem_data   = $urandom;
            if (imem_req_o !== 1'b1) mem_lat = $urandom_range(0, 3);
            if (flush_i) begin
                pc_i = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(0, 3) == 0) pc_i[1:0] = 2'($urandom_range(1, 3));
            end
            run();
            if (seen_adv) pc_i = pc_i + (($urandom_range(0, 7) == 0) ? 32'd2 : 32'd4);
        end
        rst = 1'b0; flush_i = 1'b0; ce_i = 1'b0;
        run();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
